// File: rtl/fxp_disp_pkg.sv
// Shared constants, display codes and FSM state for the fixed-point display controller.
package fxp_disp_pkg;

  localparam int SIGN_BIT    = 15;
  localparam int INT_W       = 9;
  localparam int FRAC_W      = 6;
  localparam int FH_W        = 7;   // pre-scaled fraction, 0..98
  localparam int INT_BCD_W   = 12;  // hundreds, tens, units
  localparam int FRAC_BCD_W  = 8;   // tenths, hundredths
  localparam int CONV_EDGES  = 9;
  localparam int FRAC_SHIFTS = 7;
  localparam int NUM_DIGITS  = 5;

  // Active-high {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef logic [3:0] disp_code_t;
  localparam disp_code_t CODE_DASH  = 4'hA;
  localparam disp_code_t CODE_BLANK = 4'hF;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // frac/64 expressed in hundredths, truncated
  function automatic logic [FH_W-1:0] prescale(input logic [FRAC_W-1:0] f);
    return FH_W'((13'(f) * 13'd100) >> FRAC_W);
  endfunction

endpackage

// File: rtl/fxp_seg7_encode.sv
// Display code to active-high 7-segment pattern; unknown codes render blank.
module fxp_seg7_encode
  import fxp_disp_pkg::*;
(
  input  disp_code_t  code,
  output logic [6:0]  pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    case (code)
      4'd0:      pattern = SEG_0;
      4'd1:      pattern = SEG_1;
      4'd2:      pattern = SEG_2;
      4'd3:      pattern = SEG_3;
      4'd4:      pattern = SEG_4;
      4'd5:      pattern = SEG_5;
      4'd6:      pattern = SEG_6;
      4'd7:      pattern = SEG_7;
      4'd8:      pattern = SEG_8;
      4'd9:      pattern = SEG_9;
      CODE_DASH: pattern = SEG_DASH;
      default:   pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/fxp_display_ctrl.sv
// Sign-magnitude fixed-point result to 5-digit multiplexed 7-segment display,
// with a sequential double-dabble converter and a free-running digit scanner.
module fxp_display_ctrl
  import fxp_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        busy,
  output logic        overflow,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [4:0]  an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);

  state_t state, state_nx;

  logic                  accept;
  logic [3:0]            conv_cnt;
  logic                  sign;
  logic                  mag_nz;
  logic [INT_W-1:0]      int_bin;
  logic [INT_BCD_W-1:0]  int_bcd;
  logic [FH_W-1:0]       frac_bin;
  logic [FRAC_BCD_W-1:0] frac_bcd;
  logic [INT_BCD_W-1:0]  int_adj;
  logic [FRAC_BCD_W-1:0] frac_adj;
  logic                  over_q;

  disp_code_t [NUM_DIGITS-1:0] disp;

  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;
  assign accept   = in_valid && in_ready;
  assign overflow = over_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = CONV;
      CONV:    if (conv_cnt == 4'(CONV_EDGES - 1)) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // add-3 correction ahead of each shift
  always_comb begin
    int_adj  = {add3(int_bcd[11:8]), add3(int_bcd[7:4]), add3(int_bcd[3:0])};
    frac_adj = {add3(frac_bcd[7:4]), add3(frac_bcd[3:0])};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conv_cnt <= '0;
      sign     <= 1'b0;
      mag_nz   <= 1'b0;
      int_bin  <= '0;
      int_bcd  <= '0;
      frac_bin <= '0;
      frac_bcd <= '0;
      over_q   <= 1'b0;
      disp     <= {NUM_DIGITS{CODE_BLANK}};
    end else begin
      case (state)
        IDLE: if (accept) begin
          conv_cnt <= '0;
          sign     <= in_data[SIGN_BIT];
          mag_nz   <= |in_data[SIGN_BIT-1:0];
          int_bin  <= in_data[FRAC_W +: INT_W];
          int_bcd  <= '0;
          frac_bin <= prescale(in_data[FRAC_W-1:0]);
          frac_bcd <= '0;
        end
        CONV: begin
          conv_cnt <= conv_cnt + 4'd1;
          int_bcd  <= INT_BCD_W'({int_adj, int_bin[INT_W-1]});
          int_bin  <= {int_bin[INT_W-2:0], 1'b0};
          if (conv_cnt < 4'(FRAC_SHIFTS)) begin
            frac_bcd <= FRAC_BCD_W'({frac_adj, frac_bin[FH_W-1]});
            frac_bin <= {frac_bin[FH_W-2:0], 1'b0};
          end
        end
        COMMIT: begin
          over_q  <= (int_bcd[11:8] != 4'd0);
          // negative zero is shown without a sign
          disp[0] <= (sign && mag_nz) ? CODE_DASH : CODE_BLANK;
          if (int_bcd[11:8] != 4'd0) begin
            disp[1] <= CODE_DASH;
            disp[2] <= CODE_DASH;
            disp[3] <= CODE_DASH;
            disp[4] <= CODE_DASH;
          end else begin
            disp[1] <= (int_bcd[7:4] == 4'd0) ? CODE_BLANK : int_bcd[7:4];
            disp[2] <= int_bcd[3:0];
            disp[3] <= frac_bcd[7:4];
            disp[4] <= frac_bcd[3:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Scanner: independent of the converter, outputs lag scan_idx by one edge
  logic [CW-1:0] refresh_cnt;
  logic [2:0]    scan_idx;
  logic [6:0]    pattern;

  fxp_seg7_encode u_enc (
    .code    (disp[scan_idx]),
    .pattern (pattern)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
      an          <= 5'b11111;
      seg         <= SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
      dp          <= SEG_ACTIVE_LOW;
    end else begin
      if (refresh_cnt == REF_LAST) begin
        refresh_cnt <= '0;
        scan_idx    <= (scan_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : scan_idx + 3'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      an  <= ~(5'b10000 >> scan_idx);
      seg <= SEG_ACTIVE_LOW ? ~pattern : pattern;
      dp  <= (scan_idx == 3'd2) ^ SEG_ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_fxp_display_ctrl.sv
// Randomized and directed bench for fxp_display_ctrl against an arithmetic digit model.
module tb_fxp_display_ctrl;

  localparam int RDIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        in_ready, busy, overflow, dp;
  logic [6:0]  seg;
  logic [4:0]  an;

  fxp_display_ctrl #(.REFRESH_DIV(RDIV), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .busy(busy), .overflow(overflow),
    .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_code [5];
  logic       exp_ovf;

  function automatic logic [6:0] seg_pat(input logic [3:0] c);
    case (c)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;  4'hA: return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  // Digits from plain arithmetic on the value
  task automatic set_model(input logic [15:0] v);
    int iv, fh;
    iv = int'(v[14:6]);
    fh = int'(v[5:0]) * 100 / 64;
    exp_ovf = (iv >= 100);
    exp_code[0] = (v[15] && v[14:0] != 15'd0) ? 4'hA : 4'hF;
    if (exp_ovf) begin
      for (int p = 1; p < 5; p++) exp_code[p] = 4'hA;
    end else begin
      exp_code[1] = (iv / 10 == 0) ? 4'hF : 4'(iv / 10);
      exp_code[2] = 4'(iv % 10);
      exp_code[3] = 4'(fh / 10);
      exp_code[4] = 4'(fh % 10);
    end
  endtask

  task automatic check_display(input string name);
    int pos;
    logic [4:0] oh;
    for (int c = 0; c < 5 * RDIV; c++) begin
      @(negedge clk);
      pos = -1;
      for (int p = 0; p < 5; p++) begin
        oh = ~(5'b10000 >> p);
        if (an === oh) pos = p;
      end
      checks++;
      if (pos < 0) begin
        errors++;
        $display("FAIL %s an_onehot got %b required one low bit", name, an);
      end else begin
        if (seg !== ~seg_pat(exp_code[pos])) begin
          errors++;
          $display("FAIL %s seg pos%0d got %h required %h", name, pos, seg, ~seg_pat(exp_code[pos]));
        end
        checks++;
        if (dp !== (pos != 2)) begin
          errors++;
          $display("FAIL %s dp pos%0d got %b required %b", name, pos, dp, (pos != 2));
        end
      end
    end
  endtask

  task automatic send(input logic [15:0] v, input string name);
    int waitc = 0;
    logic prev;
    @(negedge clk);
    while (!in_ready && waitc < 50) begin @(negedge clk); waitc++; end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL %s ready_wait got 0 required 1", name);
      return;
    end
    in_valid = 1'b1;
    in_data  = v;
    prev = exp_ovf;
    set_model(v);
    @(posedge clk);
    @(negedge clk);
    in_data = ~v;  // offered while busy, must be ignored
    for (int j = 0; j <= 10; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 5) in_valid = 1'b0;
      checks++;
      if (in_ready !== (j == 10)) begin
        errors++;
        $display("FAIL %s in_ready edge%0d got %b required %b", name, j, in_ready, (j == 10));
      end
      checks++;
      if (busy !== ~in_ready) begin
        errors++;
        $display("FAIL %s busy edge%0d got %b required %b", name, j, busy, ~in_ready);
      end
      if (j == 9 || j == 10) begin
        checks++;
        if (overflow !== ((j == 9) ? prev : exp_ovf)) begin
          errors++;
          $display("FAIL %s overflow edge%0d got %b required %b", name, j, overflow,
                   (j == 9) ? prev : exp_ovf);
        end
      end
    end
    check_display(name);
  endtask

  task automatic test_reset();
    logic [4:0] exp_an;
    int idx;
    for (int p = 0; p < 5; p++) exp_code[p] = 4'hF;
    exp_ovf = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b required 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b required 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow got %b required 0", overflow); end
    checks++; if (an !== 5'b11111) begin errors++; $display("FAIL reset an got %b required 11111", an); end
    checks++; if (seg !== 7'h7F || dp !== 1'b1) begin errors++; $display("FAIL reset seg_dp got %h/%b required 7f/1", seg, dp); end
    rst_n = 1'b1;
    for (int k = 1; k <= 5 * RDIV; k++) begin
      @(negedge clk);
      idx = ((k - 1) / RDIV) % 5;
      exp_an = ~(5'b10000 >> idx);
      checks++;
      if (an !== exp_an || seg !== 7'h7F || dp !== (idx != 2)) begin
        errors++;
        $display("FAIL reset_scan cyc%0d an/seg/dp got %b/%h/%b required %b/7f/%b",
                 k, an, seg, dp, exp_an, (idx != 2));
      end
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h15C8;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);  // now in the 5th conversion cycle
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || an !== 5'b11111) begin
      errors++;
      $display("FAIL abort_reset in_ready/an got %b/%b required 1/11111", in_ready, an);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL abort_idle cyc%0d in_ready/overflow got %b/%b required 1/0", k, in_ready, overflow);
      end
    end
    check_display("abort_blank");
  endtask

  task automatic test_directed();
    send(16'h15C8, "p87_125");
    send(16'h95E0, "n87_5");
    send(16'h8000, "neg_zero");
    send(16'h18FF, "p99_98");
    send(16'h1900, "p100");
    send(16'h7FFF, "p511");
    send(16'hFFFF, "n511");
    send(16'h0001, "p0_01");
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [3];
    logic prev;
    int waitc = 0;
    vals[0] = 16'h1900; vals[1] = 16'h15C8; vals[2] = 16'h95E0;
    @(negedge clk);
    while (!in_ready && waitc < 50) begin @(negedge clk); waitc++; end
    in_valid = 1'b1;
    in_data  = vals[0];
    for (int k = 0; k < 3; k++) begin
      prev = exp_ovf;
      set_model(vals[k]);
      @(posedge clk);
      @(negedge clk);
      if (k < 2) in_data = vals[k + 1];
      else       in_valid = 1'b0;
      for (int j = 0; j <= 10; j++) begin
        if (j > 0) @(negedge clk);
        checks++;
        if (in_ready !== (j == 10)) begin
          errors++;
          $display("FAIL b2b v%0d in_ready edge%0d got %b required %b", k, j, in_ready, (j == 10));
        end
        if (j == 9 || j == 10) begin
          checks++;
          if (overflow !== ((j == 9) ? prev : exp_ovf)) begin
            errors++;
            $display("FAIL b2b v%0d overflow edge%0d got %b required %b", k, j, overflow,
                     (j == 9) ? prev : exp_ovf);
          end
        end
      end
    end
    check_display("b2b_final");
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int n = 0; n < 10; n++) begin
      if (n % 2 == 0) v = 16'($urandom_range(0, 65535));
      else v = {1'($urandom_range(0, 1)), 9'($urandom_range(0, 99)), 6'($urandom_range(0, 63))};
      send(v, "random");
    end
  endtask

  initial begin
    test_reset();
    test_abort();
    test_directed();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running required finished");
    $fatal(1, "timeout");
  end

endmodule
